bitstream_feeder: RTL and testbench

BITSTREAM_FEEDER -- requirements
Module: bitstream_feeder

---
 rtl/bitstream_feeder.sv | 134 +++++++++++++
 tb/tb_bitstream_feeder.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_feeder.sv
// Bitstream feeder: buffers upstream image words in a small FIFO and hands
// them to the decoder on request. After the final word has drained, it pads
// with MAX_FILL all-ones words and then idles until restart.
//
// state  | meaning
// -------+---------------------------------------------------------------
// STREAM | accepting upstream words, serving the decoder from the FIFO
// TAIL   | final word accepted; draining the FIFO, no more writes
// FILL   | FIFO empty; serving all-ones fill words on request
// DONE   | all fill words issued; idle until restart or rst

`ifndef IN_BUS_WIDTH
`define IN_BUS_WIDTH 32
`endif

module bitstream_feeder #(
    parameter int BUS_W    = `IN_BUS_WIDTH,
    parameter int DEPTH    = 8,
    parameter int MAX_FILL = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_valid,
    input  logic [BUS_W-1:0] wr_data,
    input  logic             wr_last,
    output logic             wr_ready,
    input  logic             request,
    output logic [BUS_W-1:0] data_in,
    output logic             valid_in,
    input  logic             restart,
    output logic             fill_active,
    output logic             stream_done,
    output logic [31:0]      words_sent
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int FW = (MAX_FILL > 1) ? $clog2(MAX_FILL + 1) : 1;
    localparam logic [AW:0]   DEPTH_C   = (AW + 1)'(DEPTH);
    localparam logic [AW:0]   ONE_C     = (AW + 1)'(1);
    localparam logic [FW-1:0] FILL_LAST = FW'(MAX_FILL - 1);

    typedef enum logic [1:0] {STREAM, TAIL, FILL, DONE} state_t;

    state_t           state;
    logic [BUS_W-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic [FW-1:0]    fill_cnt;
    logic             blocked;
    logic             push;
    logic             pop;

    // rst and restart both suppress any handshake in the cycle they are seen
    assign blocked  = rst || restart;
    // space is judged on current occupancy only, so a same-cycle pop never frees a slot
    assign wr_ready = !blocked && (state == STREAM) && (count < DEPTH_C);
    assign valid_in = !blocked && request &&
                      ((((state == STREAM) || (state == TAIL)) && (count != '0)) ||
                       (state == FILL));
    assign data_in  = !valid_in ? '0 : ((state == FILL) ? '1 : mem[rd_ptr]);
    assign push     = wr_valid && wr_ready;
    assign pop      = valid_in && (state != FILL);

    // FIFO storage; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // FIFO pointers and occupancy
    always_ff @(posedge clk) begin
        if (blocked) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            unique case ({push, pop})
                2'b10:   count <= count + ONE_C;
                2'b01:   count <= count - ONE_C;
                default: count <= count;
            endcase
        end
    end

    // delivered-word counter, saturating
    always_ff @(posedge clk) begin
        if (blocked) begin
            words_sent <= '0;
        end else if (valid_in && (words_sent != '1)) begin
            words_sent <= words_sent + 32'd1;
        end
    end

    // sequencing FSM with registered status flags
    always_ff @(posedge clk) begin
        if (blocked) begin
            state       <= STREAM;
            fill_cnt    <= '0;
            fill_active <= 1'b0;
            stream_done <= 1'b0;
        end else begin
            unique case (state)
                STREAM: begin
                    if (push && wr_last) state <= TAIL;
                end
                TAIL: begin
                    // no writes in TAIL, so the FIFO can only shrink here
                    if ((count == '0) || ((count == ONE_C) && pop)) begin
                        state       <= FILL;
                        fill_active <= 1'b1;
                    end
                end
                FILL: begin
                    if (valid_in) begin
                        fill_cnt <= fill_cnt + FW'(1);
                        if (fill_cnt == FILL_LAST) begin
                            state       <= DONE;
                            fill_active <= 1'b0;
                            stream_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= DONE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitstream_feeder.sv
// Self-checking bench for bitstream_feeder: directed scenarios plus a
// randomized stream checked against a queue-based reference model.

module tb_bitstream_feeder;

    localparam int BUS_W    = 32;
    localparam int DEPTH    = 8;
    localparam int MAX_FILL = 16;
    localparam logic [BUS_W-1:0] ONES = '1;

    logic             clk = 1'b0;
    logic             rst;
    logic             wr_valid;
    logic [BUS_W-1:0] wr_data;
    logic             wr_last;
    logic             wr_ready;
    logic             request;
    logic [BUS_W-1:0] data_in;
    logic             valid_in;
    logic             restart;
    logic             fill_active;
    logic             stream_done;
    logic [31:0]      words_sent;

    int checks   = 0;
    int failures = 0;

    bitstream_feeder #(.BUS_W(BUS_W), .DEPTH(DEPTH), .MAX_FILL(MAX_FILL)) dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .wr_data(wr_data),
        .wr_last(wr_last), .wr_ready(wr_ready), .request(request),
        .data_in(data_in), .valid_in(valid_in), .restart(restart),
        .fill_active(fill_active), .stream_done(stream_done),
        .words_sent(words_sent)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    task automatic to_neg;
        @(negedge clk);
    endtask

    task automatic to_next;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        wr_valid = 1'b0; wr_data = '0; wr_last = 1'b0;
        request = 1'b0; restart = 1'b0; rst = 1'b0;
    endtask

    task automatic test_reset;
        idle_inputs();
        rst = 1'b1;
        to_next();
        to_neg();
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", valid_in); end
        checks++; if (data_in !== '0) begin failures++; $display("FAIL reset_data got=%h exp=0", data_in); end
        checks++; if (fill_active !== 1'b0) begin failures++; $display("FAIL reset_fill got=%0b exp=0", fill_active); end
        checks++; if (stream_done !== 1'b0) begin failures++; $display("FAIL reset_done got=%0b exp=0", stream_done); end
        checks++; if (words_sent !== 32'd0) begin failures++; $display("FAIL reset_words got=%0d exp=0", words_sent); end
        to_next();
        rst = 1'b0;
        request = 1'b1;
        to_neg();
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", wr_ready); end
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL reset_valid_req got=%0b exp=0", valid_in); end
        to_next();
        request = 1'b0;
    endtask

    // restart pulse with a write and a request in the same cycle; both must be ignored
    task automatic test_restart;
        restart = 1'b1; request = 1'b1; wr_valid = 1'b1; wr_data = 32'h5555_0000; wr_last = 1'b0;
        to_neg();
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL restart_valid got=%0b exp=0", valid_in); end
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL restart_ready got=%0b exp=0", wr_ready); end
        to_next();
        restart = 1'b0; wr_valid = 1'b0;
        to_neg();
        checks++; if (words_sent !== 32'd0) begin failures++; $display("FAIL restart_words got=%0d exp=0", words_sent); end
        checks++; if (fill_active !== 1'b0) begin failures++; $display("FAIL restart_fill got=%0b exp=0", fill_active); end
        checks++; if (stream_done !== 1'b0) begin failures++; $display("FAIL restart_done got=%0b exp=0", stream_done); end
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL restart_ready_after got=%0b exp=1", wr_ready); end
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL restart_write_ignored got=%0b exp=0", valid_in); end
        to_next();
        request = 1'b0;
    endtask

    task automatic test_basic;
        logic [BUS_W-1:0] w [3];
        logic [BUS_W-1:0] exp_d;
        w[0] = 32'hA1; w[1] = 32'hA2; w[2] = 32'hA3;
        request = 1'b1;
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1; wr_data = w[i]; wr_last = (i == 2);
            to_neg();
            exp_d = (i > 0) ? w[(i > 0) ? i - 1 : 0] : '0;
            checks++; if (valid_in !== (i > 0)) begin failures++; $display("FAIL basic_valid[%0d] got=%0b exp=%0b", i, valid_in, (i > 0)); end
            checks++; if (data_in !== exp_d) begin failures++; $display("FAIL basic_data[%0d] got=%h exp=%h", i, data_in, exp_d); end
            to_next();
        end
        wr_valid = 1'b0; wr_last = 1'b0;
        to_neg();
        checks++; if (valid_in !== 1'b1 || data_in !== w[2]) begin failures++; $display("FAIL basic_last got=%0b/%h exp=1/%h", valid_in, data_in, w[2]); end
        checks++; if (fill_active !== 1'b0) begin failures++; $display("FAIL basic_fill_early got=%0b exp=0", fill_active); end
        to_next();
        for (int i = 0; i < MAX_FILL; i++) begin
            to_neg();
            checks++; if (valid_in !== 1'b1 || data_in !== ONES) begin failures++; $display("FAIL basic_fillword[%0d] got=%0b/%h exp=1/%h", i, valid_in, data_in, ONES); end
            checks++; if (fill_active !== 1'b1) begin failures++; $display("FAIL basic_fill_active[%0d] got=%0b exp=1", i, fill_active); end
            to_next();
        end
        to_neg();
        checks++; if (stream_done !== 1'b1) begin failures++; $display("FAIL basic_done got=%0b exp=1", stream_done); end
        checks++; if (valid_in !== 1'b0 || data_in !== '0) begin failures++; $display("FAIL basic_done_valid got=%0b/%h exp=0/0", valid_in, data_in); end
        checks++; if (fill_active !== 1'b0) begin failures++; $display("FAIL basic_done_fill got=%0b exp=0", fill_active); end
        checks++; if (words_sent !== 32'd19) begin failures++; $display("FAIL basic_words got=%0d exp=19", words_sent); end
        to_next();
        request = 1'b0;
    endtask

    task automatic test_full;
        logic [BUS_W-1:0] w [DEPTH + 1];
        for (int i = 0; i <= DEPTH; i++) w[i] = $urandom;
        request = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_valid = 1'b1; wr_data = w[i]; wr_last = 1'b0;
            to_neg();
            checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_ready[%0d] got=%0b exp=1", i, wr_ready); end
            to_next();
        end
        wr_data = w[DEPTH];
        to_neg();
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready_full got=%0b exp=0", wr_ready); end
        to_next();
        request = 1'b1; wr_last = 1'b1;
        to_neg();
        checks++; if (wr_ready !== 1'b0) begin failures++; $display("FAIL full_ready_popcycle got=%0b exp=0", wr_ready); end
        checks++; if (valid_in !== 1'b1 || data_in !== w[0]) begin failures++; $display("FAIL full_pop0 got=%0b/%h exp=1/%h", valid_in, data_in, w[0]); end
        to_next();
        request = 1'b0;
        to_neg();
        checks++; if (wr_ready !== 1'b1) begin failures++; $display("FAIL full_ready_back got=%0b exp=1", wr_ready); end
        to_next();
        wr_valid = 1'b0; wr_last = 1'b0; request = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            to_neg();
            checks++; if (valid_in !== 1'b1 || data_in !== w[i]) begin failures++; $display("FAIL full_drain[%0d] got=%0b/%h exp=1/%h", i, valid_in, data_in, w[i]); end
            to_next();
        end
        to_neg();
        checks++; if (fill_active !== 1'b1) begin failures++; $display("FAIL full_fill got=%0b exp=1", fill_active); end
        to_next();
        request = 1'b0;
    endtask

    task automatic test_no_bypass;
        logic [BUS_W-1:0] w;
        w = $urandom;
        wr_valid = 1'b1; wr_data = w; wr_last = 1'b1; request = 1'b1;
        to_neg();
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL nobypass_same got=%0b exp=0", valid_in); end
        to_next();
        wr_valid = 1'b0; wr_last = 1'b0;
        to_neg();
        checks++; if (valid_in !== 1'b1 || data_in !== w) begin failures++; $display("FAIL nobypass_next got=%0b/%h exp=1/%h", valid_in, data_in, w); end
        to_next();
        to_neg();
        checks++; if (fill_active !== 1'b1) begin failures++; $display("FAIL nobypass_fill got=%0b exp=1", fill_active); end
        to_next();
        request = 1'b0;
    endtask

    task automatic test_restart_fill;
        logic [BUS_W-1:0] w0, b1, b2;
        w0 = $urandom; b1 = $urandom; b2 = $urandom;
        wr_valid = 1'b1; wr_data = w0; wr_last = 1'b1; request = 1'b0;
        to_next();
        wr_valid = 1'b0; wr_last = 1'b0; request = 1'b1;
        to_neg();
        checks++; if (valid_in !== 1'b1 || data_in !== w0) begin failures++; $display("FAIL rfill_word got=%0b/%h exp=1/%h", valid_in, data_in, w0); end
        to_next();
        for (int i = 0; i < 5; i++) begin
            to_neg();
            checks++; if (valid_in !== 1'b1 || data_in !== ONES) begin failures++; $display("FAIL rfill_fill[%0d] got=%0b/%h exp=1/%h", i, valid_in, data_in, ONES); end
            to_next();
        end
        request = 1'b0;
        to_neg();
        checks++; if (words_sent !== 32'd6 || fill_active !== 1'b1) begin failures++; $display("FAIL rfill_prerestart got=%0d/%0b exp=6/1", words_sent, fill_active); end
        to_next();
        test_restart();
        wr_valid = 1'b1; wr_data = b1;
        to_next();
        wr_data = b2; wr_last = 1'b1;
        to_next();
        wr_valid = 1'b0; wr_last = 1'b0; request = 1'b1;
        to_neg();
        checks++; if (valid_in !== 1'b1 || data_in !== b1) begin failures++; $display("FAIL rfill_new0 got=%0b/%h exp=1/%h", valid_in, data_in, b1); end
        to_next();
        to_neg();
        checks++; if (valid_in !== 1'b1 || data_in !== b2) begin failures++; $display("FAIL rfill_new1 got=%0b/%h exp=1/%h", valid_in, data_in, b2); end
        to_next();
        to_neg();
        checks++; if (fill_active !== 1'b1 || words_sent !== 32'd2) begin failures++; $display("FAIL rfill_newfill got=%0b/%0d exp=1/2", fill_active, words_sent); end
        to_next();
        request = 1'b0;
    endtask

    task automatic test_rst_mid;
        logic [BUS_W-1:0] c;
        c = $urandom;
        request = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1; wr_data = $urandom;
            to_next();
        end
        wr_valid = 1'b0; rst = 1'b1; request = 1'b1;
        to_neg();
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL rstmid_during got=%0b exp=0", valid_in); end
        to_next();
        rst = 1'b0;
        to_neg();
        checks++; if (valid_in !== 1'b0 || data_in !== '0) begin failures++; $display("FAIL rstmid_after got=%0b/%h exp=0/0", valid_in, data_in); end
        checks++; if (wr_ready !== 1'b1 || words_sent !== 32'd0) begin failures++; $display("FAIL rstmid_state got=%0b/%0d exp=1/0", wr_ready, words_sent); end
        to_next();
        wr_valid = 1'b1; wr_data = c; wr_last = 1'b1;
        to_neg();
        checks++; if (valid_in !== 1'b0) begin failures++; $display("FAIL rstmid_nobypass got=%0b exp=0", valid_in); end
        to_next();
        wr_valid = 1'b0; wr_last = 1'b0;
        to_neg();
        checks++; if (valid_in !== 1'b1 || data_in !== c) begin failures++; $display("FAIL rstmid_first got=%0b/%h exp=1/%h", valid_in, data_in, c); end
        to_next();
        request = 1'b0;
    endtask

    // reference: a plain queue of accepted words, visible from the cycle after acceptance
    task automatic test_random;
        logic [BUS_W-1:0] model [$];
        logic [BUS_W-1:0] sent [$];
        logic [BUS_W-1:0] got [$];
        logic             last_taken;
        logic             exp_ready, exp_valid;
        logic [BUS_W-1:0] exp_data;
        int               n_sent, cycles, valid_cycles, bad;
        last_taken = 1'b0; n_sent = 0; cycles = 0; valid_cycles = 0; bad = 0;
        while (got.size() < 200 && cycles < 5000) begin
            wr_valid = (n_sent < 200) && ($urandom_range(0, 2) != 0);
            wr_data  = $urandom;
            wr_last  = (n_sent == 199);
            request  = ($urandom_range(0, 2) != 0);
            to_neg();
            exp_ready = !last_taken && (model.size() < DEPTH);
            exp_valid = request && (model.size() > 0);
            exp_data  = exp_valid ? model[0] : '0;
            checks++; if (wr_ready !== exp_ready) begin failures++; $display("FAIL rand_ready[%0d] got=%0b exp=%0b", cycles, wr_ready, exp_ready); end
            checks++; if (valid_in !== exp_valid || data_in !== exp_data) begin failures++; $display("FAIL rand_out[%0d] got=%0b/%h exp=%0b/%h", cycles, valid_in, data_in, exp_valid, exp_data); end
            if (exp_valid) begin
                got.push_back(data_in);
                void'(model.pop_front());
                valid_cycles++;
            end
            if (wr_valid && exp_ready) begin
                model.push_back(wr_data);
                sent.push_back(wr_data);
                n_sent++;
                if (wr_last) last_taken = 1'b1;
            end
            to_next();
            cycles++;
        end
        wr_valid = 1'b0; wr_last = 1'b0; request = 1'b0;
        checks++; if (cycles >= 5000) begin failures++; $display("FAIL rand_timeout got=%0d words exp=200", got.size()); end
        for (int i = 0; i < got.size() && i < sent.size(); i++) if (got[i] !== sent[i]) bad++;
        checks++; if (bad != 0 || got.size() != sent.size()) begin failures++; $display("FAIL rand_sequence got=%0d mismatched words (sizes %0d/%0d) exp=0", bad, got.size(), sent.size()); end
        to_neg();
        checks++; if (words_sent !== 32'(valid_cycles)) begin failures++; $display("FAIL rand_words got=%0d exp=%0d", words_sent, valid_cycles); end
        checks++; if (fill_active !== 1'b1) begin failures++; $display("FAIL rand_fill got=%0b exp=1", fill_active); end
        to_next();
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        test_reset();
        test_basic();
        test_restart();
        test_full();
        test_restart();
        test_no_bypass();
        test_restart();
        test_restart_fill();
        test_restart();
        test_rst_mid();
        test_restart();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
